// File: rtl/of_pkg.sv
// Shared types and helpers for operand_fetch: FSM states, forwarding-select codes,
// and the selection and load-use hazard rules used by both operand paths.
package of_pkg;

    localparam int REG_W = 5;

    typedef enum logic {
        RUN     = 1'b0,
        LDSTALL = 1'b1
    } of_state_e;

    typedef enum logic [1:0] {
        SEL_RF  = 2'd0,
        SEL_EX  = 2'd1,
        SEL_MEM = 2'd2,
        SEL_WB  = 2'd3
    } fwd_sel_e;

    // Youngest matching producer wins; a load in EX has no data yet and is skipped.
    function automatic fwd_sel_e fwd_select(
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] ex_rd,
        input logic             ex_wr,
        input logic             ex_load,
        input logic [REG_W-1:0] mem_rd,
        input logic             mem_wr,
        input logic [REG_W-1:0] wb_rd,
        input logic             wb_wr,
        input logic             wb_en
    );
        if (ex_wr && !ex_load && (ex_rd == rs)) return SEL_EX;
        if (mem_wr && (mem_rd == rs)) return SEL_MEM;
        if (wb_en && wb_wr && (wb_rd == rs)) return SEL_WB;
        return SEL_RF;
    endfunction

    function automatic logic load_use_hazard(
        input logic             id_valid,
        input logic             use1,
        input logic [REG_W-1:0] rs1,
        input logic             use2,
        input logic [REG_W-1:0] rs2,
        input logic             ex_load,
        input logic             ex_wr,
        input logic [REG_W-1:0] ex_rd
    );
        logic hit1;
        logic hit2;
        hit1 = use1 && (rs1 == ex_rd);
        hit2 = use2 && (rs2 == ex_rd);
        return id_valid && ex_load && ex_wr && (ex_rd != '0) && (hit1 || hit2);
    endfunction

endpackage

// File: rtl/of_fwd_mux.sv
// Per-operand bypass selector; x0 always reads as zero.
// The WB bypass leg exists only when OF_WB_BYPASS_EN is defined.
module of_fwd_mux
    import of_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [REG_W-1:0]  rs,
    input  logic [DATA_W-1:0] rf_rd,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_wr,
    input  logic              ex_load,
    input  logic [DATA_W-1:0] ex_res,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic              mem_wr,
    input  logic [DATA_W-1:0] mem_res,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic              wb_wr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] operand
);

`ifdef OF_WB_BYPASS_EN
    localparam logic WB_EN = 1'b1;
`else
    // Without the bypass the register file's write-then-read supplies WB data.
    localparam logic WB_EN = 1'b0;
    logic unused_wb;
    assign unused_wb = ^wb_data;
`endif

    fwd_sel_e sel;

    assign sel = fwd_select(rs, ex_rd, ex_wr, ex_load, mem_rd, mem_wr, wb_rd, wb_wr, WB_EN);

    always_comb begin
        operand = rf_rd;
        if (rs == '0) begin
            operand = '0;
        end else begin
            case (sel)
                SEL_EX:  operand = ex_res;
                SEL_MEM: operand = mem_res;
`ifdef OF_WB_BYPASS_EN
                SEL_WB:  operand = wb_data;
`endif
                default: operand = rf_rd;
            endcase
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// ID/EX operand fetch: register-file addressing, EX/MEM(/WB) bypassing, one-cycle
// load-use interlock, EX backpressure and flush. WB bypass gated by OF_WB_BYPASS_EN.
module operand_fetch
    import of_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    output logic [REG_W-1:0]  rf_a1,
    output logic [REG_W-1:0]  rf_a2,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic              ex_wr,
    input  logic              mem_wr,
    input  logic              wb_wr,
    input  logic              ex_load,
    input  logic [DATA_W-1:0] ex_res,
    input  logic [DATA_W-1:0] mem_res,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [REG_W-1:0]  ex_rs1,
    output logic [REG_W-1:0]  ex_rs2
);

    of_state_e         state;
    of_state_e         state_next;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic              hazard;
    logic              hold;
    logic              ex_valid_next;
    logic              load_en;

    assign rf_a1 = id_rs1;
    assign rf_a2 = id_rs2;

    of_fwd_mux #(.DATA_W(DATA_W)) u_fwd1 (
        .rs(id_rs1), .rf_rd(rf_rd1),
        .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_load(ex_load), .ex_res(ex_res),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_res(mem_res),
        .wb_rd(wb_rd), .wb_wr(wb_wr), .wb_data(wb_data),
        .operand(op1)
    );

    of_fwd_mux #(.DATA_W(DATA_W)) u_fwd2 (
        .rs(id_rs2), .rf_rd(rf_rd2),
        .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_load(ex_load), .ex_res(ex_res),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_res(mem_res),
        .wb_rd(wb_rd), .wb_wr(wb_wr), .wb_data(wb_data),
        .operand(op2)
    );

    assign hazard = load_use_hazard(id_valid, id_use1, id_rs1, id_use2, id_rs2,
                                    ex_load, ex_wr, ex_rd);
    assign hold   = ex_valid && !ex_ready;

    // Stall is raised in the cycle that detects the load-use pair; the LDSTALL
    // cycle that follows carries the bubble while the load moves to MEM.
    always_comb begin
        state_next    = state;
        stall         = 1'b0;
        ex_valid_next = ex_valid;
        load_en       = 1'b0;
        if (rst) begin
            state_next    = RUN;
            ex_valid_next = 1'b0;
        end else if (flush) begin
            state_next    = RUN;
            ex_valid_next = 1'b0;
            load_en       = 1'b1;
        end else if (hold) begin
            stall = 1'b1;
        end else begin
            load_en = 1'b1;
            case (state)
                RUN: begin
                    if (hazard) begin
                        stall         = 1'b1;
                        ex_valid_next = 1'b0;
                        state_next    = LDSTALL;
                    end else begin
                        ex_valid_next = id_valid;
                    end
                end
                LDSTALL: begin
                    state_next    = RUN;
                    ex_valid_next = id_valid;
                end
                default: begin
                    state_next    = RUN;
                    ex_valid_next = 1'b0;
                end
            endcase
        end
    end

    // ID -> EX register boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            ex_valid <= 1'b0;
            ex_op1   <= '0;
            ex_op2   <= '0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
        end else begin
            state    <= state_next;
            ex_valid <= ex_valid_next;
            if (load_en) begin
                ex_op1 <= op1;
                ex_op2 <= op2;
                ex_rs1 <= id_rs1;
                ex_rs2 <= id_rs2;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed vector table, hand sequences for
// multi-cycle cases, then random traffic against a priority-list reference model.
module tb_operand_fetch;

`ifdef OF_WB_BYPASS_EN
    localparam bit          WB_ON = 1'b1;
    localparam logic [31:0] WB9   = 32'hC9;
`else
    localparam bit          WB_ON = 1'b0;
    localparam logic [31:0] WB9   = 32'h19;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid, id_use1, id_use2;
    logic [4:0]  id_rs1, id_rs2, rf_a1, rf_a2;
    logic [31:0] rf_rd1, rf_rd2;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic        ex_wr, mem_wr, wb_wr, ex_load;
    logic [31:0] ex_res, mem_res, wb_data;
    logic        flush, ex_ready;
    logic        stall, ex_valid;
    logic [31:0] ex_op1, ex_op2;
    logic [4:0]  ex_rs1, ex_rs2;

    int n_cmp = 0;
    int n_bad = 0;

    operand_fetch #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_use1(id_use1), .id_use2(id_use2),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_wr(ex_wr), .mem_wr(mem_wr), .wb_wr(wb_wr), .ex_load(ex_load),
        .ex_res(ex_res), .mem_res(mem_res), .wb_data(wb_data),
        .flush(flush), .ex_ready(ex_ready),
        .stall(stall), .ex_valid(ex_valid),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        id_valid = 0; id_use1 = 0; id_use2 = 0; id_rs1 = 0; id_rs2 = 0;
        rf_rd1 = 0; rf_rd2 = 0;
        ex_rd = 0; ex_wr = 0; ex_load = 0; ex_res = 0;
        mem_rd = 0; mem_wr = 0; mem_res = 0;
        wb_rd = 0; wb_wr = 0; wb_data = 0;
        flush = 0; ex_ready = 1;
    endtask

    task automatic idle_cycle();
        set_idle();
        @(posedge clk); #1;
        @(negedge clk);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string       name;
        logic        v, u1, u2;
        logic [4:0]  rs1, rs2;
        logic [31:0] rf1, rf2;
        logic [4:0]  exrd;  logic exwr, exld; logic [31:0] exres;
        logic [4:0]  mrd;   logic mwr;        logic [31:0] mres;
        logic [4:0]  wrd;   logic wwr;        logic [31:0] wdat;
        logic        e_stall, e_valid;
        logic [31:0] e_op1, e_op2;
    } vec_t;

    vec_t vecs[12];

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0]  rd;
        logic        ok;
        logic [31:0] val;
    } prod_t;

    logic        m_valid, m_after;
    logic [31:0] m_op1, m_op2;
    logic [4:0]  m_rs1, m_rs2;

    function automatic logic [31:0] ref_operand(input logic [4:0] rs, input logic [31:0] rf);
        prod_t p[3];
        p[0] = '{rd: ex_rd,  ok: ex_wr && !ex_load, val: ex_res};
        p[1] = '{rd: mem_rd, ok: mem_wr,            val: mem_res};
        p[2] = '{rd: wb_rd,  ok: WB_ON && wb_wr,    val: wb_data};
        if (rs == 5'd0) return 32'd0;
        for (int i = 0; i < 3; i++)
            if (p[i].ok && p[i].rd == rs) return p[i].val;
        return rf;
    endfunction

    function automatic logic ref_hazard();
        if (!id_valid || !ex_load || !ex_wr || ex_rd == 5'd0) return 1'b0;
        return (id_use1 && id_rs1 == ex_rd) || (id_use2 && id_rs2 == ex_rd);
    endfunction

    function automatic logic ref_stall();
        if (flush) return 1'b0;
        if (m_valid && !ex_ready) return 1'b1;
        return !m_after && ref_hazard();
    endfunction

    task automatic ref_advance();
        if (flush) begin
            m_valid = 0; m_after = 0;
        end else if (m_valid && !ex_ready) begin
            m_after = 0;
        end else if (!m_after && ref_hazard()) begin
            m_valid = 0; m_after = 1;
        end else begin
            m_valid = id_valid; m_after = 0;
            m_op1 = ref_operand(id_rs1, rf_rd1);
            m_op2 = ref_operand(id_rs2, rf_rd2);
            m_rs1 = id_rs1; m_rs2 = id_rs2;
        end
    endtask

    initial begin
        vecs[0]  = '{"ex_fwd",      1,1,0,  5, 0, 32'h99, 32'h5,   5,1,0,32'h11,  0,0,32'h0,   0,0,32'h0,  0,1,32'h11,   32'h0};
        vecs[1]  = '{"ex_over_mem", 1,1,1,  1, 3, 32'h1234,32'h3333,3,1,0,32'hA,  3,1,32'hB,   0,0,32'h0,  0,1,32'h1234, 32'hA};
        vecs[2]  = '{"x0",          1,1,1,  0, 2, 32'h77, 32'h22,  0,1,0,32'hFF,  0,1,32'hEE,  0,1,32'hDD, 0,1,32'h0,    32'h22};
        vecs[3]  = '{"mem_over_wb", 1,1,1,  4, 6, 32'hD0, 32'h66,  0,0,0,32'h0,   4,1,32'hB0,  4,1,32'hC0, 0,1,32'hB0,   32'h66};
        vecs[4]  = '{"wb_path",     1,1,0,  9, 0, 32'h19, 32'h0,   0,0,0,32'h0,   0,0,32'h0,   9,1,32'hC9, 0,1,WB9,      32'h0};
        vecs[5]  = '{"wr_off",      1,1,0,  5, 0, 32'h15, 32'h0,   5,0,0,32'h55,  5,0,32'h56,  5,0,32'h57, 0,1,32'h15,   32'h0};
        vecs[6]  = '{"load_unused", 1,0,1,  8, 1, 32'h80, 32'h81,  8,1,1,32'h88,  8,1,32'h8B,  0,0,32'h0,  0,1,32'h8B,   32'h81};
        vecs[7]  = '{"load_use2",   1,0,1,  2,10, 32'h1,  32'h2,  10,1,1,32'hAA,  0,0,32'h0,   0,0,32'h0,  1,0,32'h0,    32'h0};
        vecs[8]  = '{"load_x0",     1,1,0,  0, 0, 32'h3,  32'h0,   0,1,1,32'hAB,  0,0,32'h0,   0,0,32'h0,  0,1,32'h0,    32'h0};
        vecs[9]  = '{"load_idle",   0,1,0, 11, 0, 32'h4,  32'h0,  11,1,1,32'hAC,  0,0,32'h0,   0,0,32'h0,  0,0,32'h0,    32'h0};
        vecs[10] = '{"two_srcs",    1,1,1, 12,13, 32'h5,  32'h6,  12,1,0,32'h1C, 13,1,32'h2D,  0,0,32'h0,  0,1,32'h1C,   32'h2D};
        vecs[11] = '{"load_nowr",   1,1,0, 14, 0, 32'hE0, 32'h0,  14,0,1,32'hE1,  0,0,32'h0,   0,0,32'h0,  0,1,32'hE0,   32'h0};

        // reset state
        set_idle();
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", ex_valid, 0);
        chk("rst_op1", ex_op1, 0);
        chk("rst_op2", ex_op2, 0);
        chk("rst_rs1", ex_rs1, 0);
        chk("rst_rs2", ex_rs2, 0);
        chk("rst_stall", stall, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // directed table, an idle cycle after each vector returns the FSM to RUN
        for (int i = 0; i < 12; i++) begin
            set_idle();
            id_valid = vecs[i].v; id_use1 = vecs[i].u1; id_use2 = vecs[i].u2;
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            rf_rd1 = vecs[i].rf1; rf_rd2 = vecs[i].rf2;
            ex_rd = vecs[i].exrd; ex_wr = vecs[i].exwr; ex_load = vecs[i].exld; ex_res = vecs[i].exres;
            mem_rd = vecs[i].mrd; mem_wr = vecs[i].mwr; mem_res = vecs[i].mres;
            wb_rd = vecs[i].wrd; wb_wr = vecs[i].wwr; wb_data = vecs[i].wdat;
            #1;
            chk({vecs[i].name, "_stall"}, stall, vecs[i].e_stall);
            chk({vecs[i].name, "_rf_a1"}, rf_a1, vecs[i].rs1);
            chk({vecs[i].name, "_rf_a2"}, rf_a2, vecs[i].rs2);
            @(posedge clk); #1;
            chk({vecs[i].name, "_valid"}, ex_valid, vecs[i].e_valid);
            if (vecs[i].e_valid) begin
                chk({vecs[i].name, "_op1"}, ex_op1, vecs[i].e_op1);
                chk({vecs[i].name, "_op2"}, ex_op2, vecs[i].e_op2);
                chk({vecs[i].name, "_rs1"}, ex_rs1, vecs[i].rs1);
            end
            @(negedge clk);
            idle_cycle();
        end

        // load-use: one stall cycle with a bubble, then the load data from MEM
        set_idle();
        ex_load = 1; ex_wr = 1; ex_rd = 7; ex_res = 32'hBAD;
        id_valid = 1; id_use1 = 1; id_rs1 = 7; rf_rd1 = 32'h1111;
        #1 chk("lu_stall", stall, 1);
        @(posedge clk); #1 chk("lu_bubble", ex_valid, 0);
        @(negedge clk);
        ex_load = 0; ex_wr = 0; ex_rd = 0; mem_rd = 7; mem_wr = 1; mem_res = 32'hDEAD;
        #1 chk("lu_stall_once", stall, 0);
        @(posedge clk); #1;
        chk("lu_valid", ex_valid, 1);
        chk("lu_op1", ex_op1, 32'hDEAD);
        @(negedge clk);
        idle_cycle();

        // flush during LDSTALL
        set_idle();
        ex_load = 1; ex_wr = 1; ex_rd = 7; id_valid = 1; id_use1 = 1; id_rs1 = 7;
        #1 chk("fl_ld_stall", stall, 1);
        @(posedge clk); #1;
        @(negedge clk);
        flush = 1;
        #1 chk("fl_ld_nostall", stall, 0);
        @(posedge clk); #1 chk("fl_ld_valid", ex_valid, 0);
        @(negedge clk);
        flush = 0;
        #1 chk("fl_ld_run", stall, 1);
        @(posedge clk); #1;
        @(negedge clk);
        idle_cycle();

        // flush in the detection cycle keeps the FSM in RUN
        set_idle();
        ex_load = 1; ex_wr = 1; ex_rd = 6; id_valid = 1; id_use2 = 1; id_rs2 = 6; flush = 1;
        #1 chk("fl_det_stall", stall, 0);
        @(posedge clk); #1 chk("fl_det_valid", ex_valid, 0);
        @(negedge clk);
        flush = 0;
        #1 chk("fl_det_run", stall, 1);
        @(posedge clk); #1;
        @(negedge clk);
        idle_cycle();

        // backpressure: outputs held for three cycles
        set_idle();
        id_valid = 1; id_use1 = 1; id_use2 = 1; id_rs1 = 1; id_rs2 = 2;
        rf_rd1 = 32'hAAA1; rf_rd2 = 32'hBBB2;
        #1 chk("bp_load_stall", stall, 0);
        @(posedge clk); #1 chk("bp_load_op1", ex_op1, 32'hAAA1);
        @(negedge clk);
        ex_ready = 0; id_rs1 = 9; rf_rd1 = 32'h5555;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_stall", stall, 1);
            @(posedge clk); #1;
            chk("bp_valid", ex_valid, 1);
            chk("bp_op1", ex_op1, 32'hAAA1);
            chk("bp_op2", ex_op2, 32'hBBB2);
            chk("bp_rs1", ex_rs1, 1);
            @(negedge clk);
        end
        ex_ready = 1;
        #1 chk("bp_release_stall", stall, 0);
        @(posedge clk); #1;
        chk("bp_release_op1", ex_op1, 32'h5555);
        chk("bp_release_rs1", ex_rs1, 9);
        @(negedge clk);
        // flush beats backpressure
        ex_ready = 0; flush = 1;
        #1 chk("bp_flush_stall", stall, 0);
        @(posedge clk); #1 chk("bp_flush_valid", ex_valid, 0);
        @(negedge clk);
        idle_cycle();

        // async reset between edges while stalled
        set_idle();
        id_valid = 1; id_use1 = 1; id_rs1 = 4; rf_rd1 = 32'h4444;
        @(posedge clk); #1;
        @(negedge clk);
        ex_ready = 0; ex_load = 1; ex_wr = 1; ex_rd = 4;
        #1 chk("ar_pre_stall", stall, 1);
        rst = 1;
        #1;
        chk("ar_valid", ex_valid, 0);
        chk("ar_stall", stall, 0);
        chk("ar_op1", ex_op1, 0);
        chk("ar_rs1", ex_rs1, 0);
        #1 rst = 0;
        set_idle();
        id_valid = 1; id_use1 = 1; id_rs1 = 3; rf_rd1 = 32'h3C;
        @(posedge clk); #1;
        chk("ar_first_valid", ex_valid, 1);
        chk("ar_first_op1", ex_op1, 32'h3C);
        @(negedge clk);

        // randomized traffic against the reference model
        set_idle();
        rst = 1; #1; rst = 0;
        m_valid = 0; m_after = 0; m_op1 = 0; m_op2 = 0; m_rs1 = 0; m_rs2 = 0;
        for (int c = 0; c < 1500; c++) begin
            id_valid = ($urandom_range(0, 9) < 8);
            id_use1  = $urandom_range(0, 1);
            id_use2  = $urandom_range(0, 1);
            id_rs1   = 5'($urandom_range(0, 7));
            id_rs2   = 5'($urandom_range(0, 7));
            rf_rd1   = $urandom; rf_rd2 = $urandom;
            ex_rd    = 5'($urandom_range(0, 7));
            ex_wr    = $urandom_range(0, 1);
            ex_load  = ($urandom_range(0, 3) == 0);
            ex_res   = $urandom;
            mem_rd   = 5'($urandom_range(0, 7));
            mem_wr   = $urandom_range(0, 1);
            mem_res  = $urandom;
            wb_rd    = 5'($urandom_range(0, 7));
            wb_wr    = $urandom_range(0, 1);
            wb_data  = $urandom;
            flush    = ($urandom_range(0, 19) == 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            #1;
            chk("rnd_stall", stall, ref_stall());
            ref_advance();
            @(posedge clk); #1;
            chk("rnd_valid", ex_valid, m_valid);
            if (m_valid) begin
                chk("rnd_op1", ex_op1, m_op1);
                chk("rnd_op2", ex_op2, m_op2);
                chk("rnd_rs1", ex_rs1, m_rs1);
                chk("rnd_rs2", ex_rs2, m_rs2);
            end
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
